// File: rtl/sync_fifo_v2.sv
// Synchronous FIFO with arbitrary depth, optional first-word-fall-through,
// programmable almost-full/empty thresholds and sticky error flags.
module sync_fifo_v2 #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int FWFT  = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [CNT_W-1:0] afull_th_i,
  input  logic [CNT_W-1:0] aempty_th_i,
  input  logic             clr_err_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o,
  output logic [CNT_W-1:0] elements_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic rd_acc;
  logic wr_acc;

  always_comb begin
    rd_acc = rd_en_i & (count_q != '0) & ~flush_i;
    wr_acc = wr_en_i & ~flush_i & ((count_q != FULL) | rd_acc);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc)
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (rd_acc)
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // FWFT keeps rdata at the next head; a word landing in the head
    // slot this cycle has to bypass the array.
    if (FWFT != 0) begin
      if (count_d != '0)
        rdata_d = (wr_acc && rd_ptr_d == wr_ptr_q) ?
                  wdata_i : mem_q[rd_ptr_d];
    end else if (rd_acc) begin
      rdata_d = mem_q[rd_ptr_q];
    end

    ovf_d = (ovf_q & ~clr_err_i) | (wr_en_i & ~flush_i & ~wr_acc);
    udf_d = (udf_q & ~clr_err_i) |
            (rd_en_i & ~flush_i & (count_q == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc && !rst_i)
      mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = rdata_q;
  assign elements_o  = count_q;
  assign full_o      = (count_q == FULL);
  assign empty_o     = (count_q == '0);
  assign afull_o     = (count_q >= afull_th_i);
  assign aempty_o    = (count_q <= aempty_th_i);
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule
